// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   state_t    : transmit FSM states
//   DATA_BITS  : payload bits per frame
//   FRAME_BITS : start + payload + stop
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;
endpackage

// File: rtl/uart_tx_arbiter_bit_timer.sv
// Bit-period timer for the UART transmitter.
//   clk      : core clock
//   reset    : asynchronous, active-low
//   clear    : hold the count at 0 (asserted while the transmitter is idle)
//   bit_done : high on the last cycle of each bit period
// The counter wraps to 0 on bit_done, so every state entered on a bit_done
// edge starts with a fresh full-length period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_done = !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (clear || bit_done) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-source round-robin arbiter feeding an 8N1 UART transmitter.
//   clk, reset             : core clock, async active-low reset
//   req0_valid/data/ready  : CPU byte source (ready is combinational)
//   req1_valid/data/ready  : debug/echo byte source (ready is combinational)
//   uart_tx                : serial line, idle high, registered
//   busy                   : frame in progress
//   grant_id               : source of the current/last accepted byte
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic       grant_id
);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t               state, state_nxt;
  logic                 rr_ptr;
  logic                 sel;
  logic                 grant;
  logic                 bit_done;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 last_bit;

  assign last_bit = (bit_idx == LAST_IDX);
  assign busy     = (state != IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .bit_done (bit_done)
  );

  // Next state, grant and ready. With both sources valid, rr_ptr picks;
  // otherwise whichever source is valid wins.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    sel        = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE:  if (req0_valid || req1_valid) begin
               grant     = 1'b1;
               state_nxt = START;
             end
      START: if (bit_done) state_nxt = DATA;
      DATA:  if (bit_done && last_bit) state_nxt = STOP;
      STOP:  if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // ready must stay low while reset is asserted, even though state is IDLE
    req0_ready = reset && grant && !sel;
    req1_ready = reset && grant &&  sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Shift register drains LSB first; uart_tx is loaded one bit ahead so the
  // line changes on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uart_tx  <= 1'b1;
      grant_id <= 1'b0;
      rr_ptr   <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
    end else if (grant) begin
      shreg    <= sel ? req1_data : req0_data;
      grant_id <= sel;
      rr_ptr   <= ~sel;
      uart_tx  <= 1'b0;
      bit_idx  <= '0;
    end else if (bit_done) begin
      case (state)
        START: begin
          uart_tx <= shreg[0];
          shreg   <= shreg >> 1;
        end
        DATA: begin
          if (last_bit) begin
            uart_tx <= 1'b1;
          end else begin
            uart_tx <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, uart_tx, busy, grant_id;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .uart_tx(uart_tx), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // handshake monitor: {id, data} of every accepted byte, in grant order
  logic [8:0] acc_q[$];
  logic       gid_q[$];
  int         hs_cnt = 0, seen_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req0_valid && req0_ready) begin
      acc_q.push_back({1'b0, req0_data});
      hs_cnt <= hs_cnt + 1;
    end else if (req1_valid && req1_ready) begin
      acc_q.push_back({1'b1, req1_data});
      hs_cnt <= hs_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (hs_cnt != seen_cnt) begin
      gid_q.push_back(grant_id);
      seen_cnt <= hs_cnt;
    end
  end

  // serial decoder: mid-bit sampling, pushes {stop_bit, byte}
  logic       dact = 1'b0;
  int         dcnt = 0;
  logic [7:0] dbyte = '0;
  logic [8:0] rx_q[$];

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      dact <= 1'b0;
      dcnt <= 0;
    end else if (!dact) begin
      if (uart_tx === 1'b0) begin
        dact <= 1'b1;
        dcnt <= 1;
      end
    end else begin
      dcnt <= dcnt + 1;
      if ((dcnt % CPB) == CPB/2 && dcnt > CPB && dcnt < 9*CPB)
        dbyte <= {uart_tx, dbyte[7:1]};
      if (dcnt == 9*CPB + CPB/2) begin
        rx_q.push_back({uart_tx, dbyte});
        dact <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge. Returns on the negedge after the accept edge with
  // valid dropped; hs_cyc is the cycle stamp of the accept edge.
  task automatic send(input string tag, input bit id, input logic [7:0] d, output int hs_cyc);
    hs_cyc = -1;
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    for (int n = 0; n < 200; n++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        hs_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk({tag, "_handshake"}, (hs_cyc >= 0), 1);
  endtask

  // Called on the first negedge after the accept edge.
  task automatic check_frame(input string tag, input logic [7:0] d);
    logic [9:0] fr;
    int nbusy;
    fr = {1'b1, d, 1'b0};
    nbusy = 0;
    for (int i = 0; i < FRAME; i++) begin
      chk({tag, "_bit"}, uart_tx, fr[i / CPB]);
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, nbusy, FRAME);
    chk({tag, "_idle_tx"}, uart_tx, 1);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int c1, c2, base, gbase, rbase, nrdy, nacc, maxw, st0, st1, errs, nstop;
    bit dn0, dn1;

    // reset state, with both sources requesting
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte from req0
    send("t1", 1'b0, 8'hA5, c1);
    check_frame("t1", 8'hA5);
    chk("t1_gid", grant_id, 0);
    repeat (3) @(negedge clk);
    chk("t1_rx", rx_q[rx_q.size()-1], {1'b1, 8'hA5});

    // 2: both held valid -> 0x55, 0x0F, 0x55
    reset = 1'b0; repeat (2) @(negedge clk); reset = 1'b1; @(negedge clk);
    base = acc_q.size(); gbase = gid_q.size(); rbase = rx_q.size();
    req0_valid = 1'b1; req0_data = 8'h55;
    req1_valid = 1'b1; req1_data = 8'h0F;
    for (int n = 0; n < 300 && acc_q.size() - base < 3; n++) begin
      @(negedge clk);
      for (int k = base; k < acc_q.size(); k++)
        if (acc_q[k][8]) req1_valid = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (FRAME + 5) @(negedge clk);
    chk("t2_count", acc_q.size() - base, 3);
    chk("t2_acc0", acc_q[base],   {1'b0, 8'h55});
    chk("t2_acc1", acc_q[base+1], {1'b1, 8'h0F});
    chk("t2_acc2", acc_q[base+2], {1'b0, 8'h55});
    chk("t2_gid0", gid_q[gbase],   0);
    chk("t2_gid1", gid_q[gbase+1], 1);
    chk("t2_gid2", gid_q[gbase+2], 0);
    chk("t2_rx0", rx_q[rbase],   {1'b1, 8'h55});
    chk("t2_rx1", rx_q[rbase+1], {1'b1, 8'h0F});
    chk("t2_rx2", rx_q[rbase+2], {1'b1, 8'h55});

    // 3: req1 back-to-back, 41 cycles between handshakes
    send("t3a", 1'b1, 8'h00, c1);
    send("t3b", 1'b1, 8'hFF, c2);
    chk("t3_spacing", c2 - c1, FRAME + 1);
    check_frame("t3b", 8'hFF);
    chk("t3_gid", grant_id, 1);

    // 4: reset during DATA bit 3
    send("t4a", 1'b1, 8'hC3, c1);
    repeat (4*CPB + 1) @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h3C;
    #2 reset = 1'b0;
    #1;
    chk("t4_rst_tx", uart_tx, 1);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_gid", grant_id, 0);
    chk("t4_rst_rdy", req0_ready, 0);
    @(negedge clk);
    chk("t4_rst_rdy_held", req0_ready, 0);
    req0_valid = 1'b0;
    reset = 1'b1;
    send("t4b", 1'b0, 8'h3C, c1);
    check_frame("t4b", 8'h3C);

    // 5: req0 raised mid-frame, withdrawn before STOP ends
    repeat (2) @(negedge clk);
    send("t5", 1'b1, 8'h81, c1);
    base = acc_q.size();
    nrdy = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 10) begin req0_valid = 1'b1; req0_data = 8'h99; end
      if (i == 35) req0_valid = 1'b0;
      #1;
      if (req0_ready === 1'b1) nrdy++;
      @(negedge clk);
    end
    repeat (FRAME + 10) @(negedge clk);
    chk("t5_no_ready", nrdy, 0);
    chk("t5_no_extra", acc_q.size() - base, 0);
    chk("t5_busy", busy, 0);

    // 6: random traffic scoreboard
    base = acc_q.size(); rbase = rx_q.size();
    nacc = 0; maxw = 0; dn0 = 0; dn1 = 0; st0 = 0; st1 = 0;
    for (int c = 0; c < 60000 && nacc < 1000; c++) begin
      @(negedge clk);
      if (dn0) begin req0_valid = 1'b0; dn0 = 0; end
      if (dn1) begin req1_valid = 1'b0; dn1 = 0; end
      if (!req0_valid && $urandom_range(3) == 0) begin
        req0_valid = 1'b1; req0_data = 8'($urandom); st0 = cyc;
      end
      if (!req1_valid && $urandom_range(3) == 0) begin
        req1_valid = 1'b1; req1_data = 8'($urandom); st1 = cyc;
      end
      #1;
      if (req0_valid && req0_ready) begin
        nacc++; dn0 = 1; if (cyc - st0 > maxw) maxw = cyc - st0;
      end
      if (req1_valid && req1_ready) begin
        nacc++; dn1 = 1; if (cyc - st1 > maxw) maxw = cyc - st1;
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (FRAME + 20) @(negedge clk);
    chk("t6_accepted", nacc, 1000);
    chk("t6_acc_count", acc_q.size() - base, nacc);
    chk("t6_rx_count", rx_q.size() - rbase, nacc);
    errs = 0; nstop = 0;
    for (int k = 0; k < nacc && k < acc_q.size() - base && k < rx_q.size() - rbase; k++) begin
      if (rx_q[rbase+k][7:0] !== acc_q[base+k][7:0]) errs++;
      if (rx_q[rbase+k][8] !== 1'b1) nstop++;
    end
    chk("t6_order", errs, 0);
    chk("t6_stop_bits", nstop, 0);
    chk("t6_max_wait_ok", (maxw <= 2*(FRAME+1)), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
